// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit holding register between NUM_REQ byte-stream
// requesters. Arbitration is round-robin from a rotating pointer. With LOCK=1
// the current owner keeps the grant across consecutive bytes until it flags
// the last byte of its packet, stops presenting data, or reaches MAX_BURST
// bytes. With LOCK=0 the grant is released after every byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64,
  parameter int LOCK      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_vld,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_rdy,
  output logic [7:0]           txd,
  output logic                 tx_vld,
  input  logic                 tx_done,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int               PTR_W      = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_RST    = PTR_W'(NUM_REQ - 1);
  // cnt is compared before the increment, so the limit test is cnt == MAX_BURST-1
  localparam logic [7:0]       BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t               state_q,  state_d;
  logic [PTR_W-1:0]     ptr_q,    ptr_d;
  logic [PTR_W-1:0]     owner_q,  owner_d;
  logic [7:0]           cnt_q,    cnt_d;
  logic                 last_q,   last_d;
  logic [NUM_REQ-1:0]   grant_q,  grant_d;
  logic [7:0]           txd_q,    txd_d;
  logic                 tx_vld_q, tx_vld_d;

  logic                 pick_vld_s;
  logic [PTR_W-1:0]     pick_idx_s;
  logic                 owner_vld_s;
  logic                 owner_last_s;
  logic [7:0]           owner_data_s;
  logic                 release_s;

  // One-hot encoding of a requester index.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requester with req_vld set, starting at ptr+1 and wrapping.
  always_comb begin
    logic [PTR_W-1:0] cand;
    pick_vld_s = 1'b0;
    pick_idx_s = ptr_q;
    cand       = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld_s && req_vld[cand]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = cand;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Current owner's request lines and the end-of-grant decision taken on tx_done.
  always_comb begin
    owner_vld_s  = req_vld[owner_q];
    owner_last_s = req_last[owner_q];
    owner_data_s = req_data[{owner_q, 3'b000} +: 8];
    release_s    = (LOCK == 0) || last_q || (cnt_q == BURST_LAST) || !owner_vld_s;
  end

  // State register and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_RST;
      owner_q  <= '0;
      cnt_q    <= 8'd0;
      last_q   <= 1'b0;
      grant_q  <= '0;
      txd_q    <= 8'h00;
      tx_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      txd_q    <= txd_d;
      tx_vld_q <= tx_vld_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, take the byte in LOAD, hold it in WAIT until tx_done.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    txd_d    = txd_q;
    tx_vld_d = tx_vld_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (pick_vld_s) begin
          grant_d = to_onehot(pick_idx_s);
          owner_d = pick_idx_s;
          state_d = ST_LOAD;
        end else begin
          grant_d = '0;
        end
      end
      ST_LOAD: begin
        if (owner_vld_s) begin
          txd_d    = owner_data_s;
          last_d   = owner_last_s;
          tx_vld_d = 1'b1;
          state_d  = ST_WAIT;
        end else begin
          // owner dropped its request while granted: give the slot away
          ptr_d   = owner_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          tx_vld_d = 1'b0;
          cnt_d    = cnt_q + 8'd1;
          if (release_s) begin
            ptr_d   = owner_q;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          tx_vld_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        tx_vld_d = 1'b0;
      end
    endcase
  end

  // Outputs: ready is a same-cycle acknowledge to the owner in LOAD; busy flags any non-IDLE state.
  always_comb begin
    busy = (state_q != ST_IDLE);
    if (state_q == ST_LOAD) begin
      req_rdy = grant_q & req_vld;
    end else begin
      req_rdy = '0;
    end
  end

  assign grant  = grant_q;
  assign txd    = txd_q;
  assign tx_vld = tx_vld_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Three instances cover LOCK=1, LOCK=0 and
// MAX_BURST=2; one is active at a time. A requester model presents queued bytes
// and retires them on req_rdy, a TX model returns tx_done after a set number of
// tx_vld cycles, and a scoreboard compares every byte handed to the UART
// (instance, grant, txd) against the order the bench predicts.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] data;
    logic       last;
  } ent_t;

  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] gnt;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rn_s  [3];
  logic [31:0] rd_s  [3];
  logic [3:0]  rv_s  [3];
  logic [3:0]  rl_s  [3];
  logic [3:0]  rr_s  [3];
  logic [3:0]  gr_s  [3];
  logic [7:0]  txd_s [3];
  logic        tv_s  [3];
  logic        td_s  [3];
  logic        bz_s  [3];

  int   checks = 0;
  int   errors = 0;
  int   act = 0;
  int   dly = 10;
  int   spur_req = 0;
  int   rdy_cnt [4];
  int   max_cnt2 = 0;
  ent_t bq[$];
  exp_t eq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(64), .LOCK(1)) u_lock (
    .clk(clk), .reset_n(rn_s[0]), .req_data(rd_s[0]), .req_vld(rv_s[0]), .req_last(rl_s[0]),
    .req_rdy(rr_s[0]), .txd(txd_s[0]), .tx_vld(tv_s[0]), .tx_done(td_s[0]), .grant(gr_s[0]), .busy(bz_s[0]));

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(64), .LOCK(0)) u_nolock (
    .clk(clk), .reset_n(rn_s[1]), .req_data(rd_s[1]), .req_vld(rv_s[1]), .req_last(rl_s[1]),
    .req_rdy(rr_s[1]), .txd(txd_s[1]), .tx_vld(tv_s[1]), .tx_done(td_s[1]), .grant(gr_s[1]), .busy(bz_s[1]));

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(2), .LOCK(1)) u_burst (
    .clk(clk), .reset_n(rn_s[2]), .req_data(rd_s[2]), .req_vld(rv_s[2]), .req_last(rl_s[2]),
    .req_rdy(rr_s[2]), .txd(txd_s[2]), .tx_vld(tv_s[2]), .tx_done(td_s[2]), .grant(gr_s[2]), .busy(bz_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    ent_t e;
    e.req  = 2'(r);
    e.data = d;
    e.last = l;
    bq.push_back(e);
  endtask

  task automatic sb_push(input int d, input logic [3:0] g, input logic [7:0] b);
    exp_t e;
    e.dut  = 2'(d);
    e.gnt  = g;
    e.data = b;
    eq.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(bq.size() == 0 && eq.size() == 0 && bz_s[act] == 1'b0 && tv_s[act] == 1'b0)) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(n < budget), 32'd1);
  endtask

  // Requester model: retire a byte after its req_rdy, then present each requester's next queued byte.
  initial begin : req_model
    logic [3:0] acc;
    bit         found;
    for (int d = 0; d < 3; d++) begin
      rv_s[d] = 4'd0;
      rl_s[d] = 4'd0;
      rd_s[d] = 32'd0;
    end
    for (int r = 0; r < 4; r++) rdy_cnt[r] = 0;
    forever begin
      @(negedge clk);
      acc = rr_s[act] & rv_s[act];
      for (int r = 0; r < 4; r++) if (rr_s[act][r]) rdy_cnt[r]++;
      @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++) begin
        found = 1'b0;
        if (acc[r]) begin
          for (int i = 0; i < bq.size(); i++) begin
            if (!found && int'(bq[i].req) == r) begin
              bq.delete(i);
              found = 1'b1;
            end
          end
        end
      end
      for (int r = 0; r < 4; r++) begin
        found = 1'b0;
        rv_s[act][r]         = 1'b0;
        rl_s[act][r]         = 1'b0;
        rd_s[act][8*r +: 8]  = 8'h00;
        for (int i = 0; i < bq.size(); i++) begin
          if (!found && int'(bq[i].req) == r) begin
            found = 1'b1;
            rv_s[act][r]        = 1'b1;
            rl_s[act][r]        = bq[i].last;
            rd_s[act][8*r +: 8] = bq[i].data;
          end
        end
      end
    end
  end

  // TX model: pulse tx_done in the dly-th cycle of tx_vld, or once on request while idle.
  initial begin : tx_model
    int hc;
    int spur_ack;
    hc = 0;
    spur_ack = 0;
    for (int d = 0; d < 3; d++) td_s[d] = 1'b0;
    forever begin
      @(negedge clk);
      if (td_s[act]) begin
        td_s[act] = 1'b0;
        hc = 0;
      end else if (spur_ack != spur_req) begin
        td_s[act] = 1'b1;
        spur_ack = spur_req;
      end else if (tv_s[act]) begin
        hc++;
        if (hc >= dly) td_s[act] = 1'b1;
      end else begin
        hc = 0;
      end
    end
  end

  // Scoreboard: every rising tx_vld must match the next predicted (instance, grant, byte).
  initial begin : sb_monitor
    logic prev;
    int   pa;
    exp_t e;
    prev = 1'b0;
    pa = 0;
    forever begin
      @(negedge clk);
      if (pa != act) begin
        prev = 1'b0;
        pa = act;
      end
      if (int'(u_burst.cnt_q) > max_cnt2) max_cnt2 = int'(u_burst.cnt_q);
      if (tv_s[act] && !prev) begin
        if (eq.size() == 0) begin
          chk("sb_underflow", 32'(eq.size()), 32'd1);
        end else begin
          e = eq.pop_front();
          chk("sb_byte", 32'({2'(act), gr_s[act], txd_s[act]}), 32'(e));
        end
      end
      prev = tv_s[act];
    end
  end

  initial begin : main
    int n;
    int base [4];
    for (int d = 0; d < 3; d++) rn_s[d] = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) rn_s[d] = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_grant",  32'(gr_s[0]),  32'd0);
    chk("rst_rdy",    32'(rr_s[0]),  32'd0);
    chk("rst_txd",    32'(txd_s[0]), 32'd0);
    chk("rst_tx_vld", 32'(tv_s[0]),  32'd0);
    chk("rst_busy",   32'(bz_s[0]),  32'd0);
    chk("rst_ptr",    32'(u_lock.ptr_q), 32'd3);

    // single requester, latency and hold time
    act = 0;
    dly = 10;
    sb_push(0, 4'b0100, 8'h41);
    send(2, 8'h41, 1'b1);
    @(negedge clk);
    chk("t1_vld",       32'(rv_s[0]), 32'h4);
    chk("t1_rdy_early", 32'(rr_s[0]), 32'h0);
    @(negedge clk);
    chk("t1_rdy",       32'(rr_s[0]), 32'h4);
    chk("t1_grant",     32'(gr_s[0]), 32'h4);
    chk("t1_busy",      32'(bz_s[0]), 32'd1);
    chk("t1_tv_early",  32'(tv_s[0]), 32'd0);
    @(negedge clk);
    chk("t1_tv",        32'(tv_s[0]),  32'd1);
    chk("t1_txd",       32'(txd_s[0]), 32'h41);
    n = 1;
    while (tv_s[0] && n < 40) begin
      @(negedge clk);
      if (tv_s[0]) n++;
    end
    chk("t1_hold",    32'(n), 32'd10);
    chk("t1_release", 32'(gr_s[0]), 32'd0);
    chk("t1_idle",    32'(bz_s[0]), 32'd0);
    chk("t1_ptr",     32'(u_lock.ptr_q), 32'd2);

    // locked packet "ABC" from req 1 while req 3 waits
    dly = 3;
    sb_push(0, 4'b0010, 8'h41);
    sb_push(0, 4'b0010, 8'h42);
    sb_push(0, 4'b0010, 8'h43);
    sb_push(0, 4'b1000, 8'h5A);
    send(1, 8'h41, 1'b0);
    send(1, 8'h42, 1'b0);
    send(1, 8'h43, 1'b1);
    n = 0;
    while (gr_s[0] != 4'b0010 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("lk_grant1", 32'(gr_s[0]), 32'h2);
    send(3, 8'h5A, 1'b1);
    wait_drain(200);
    chk("lk_ptr", 32'(u_lock.ptr_q), 32'd3);

    // spurious tx_done while idle
    spur_req++;
    repeat (3) @(negedge clk);
    chk("sp_busy",  32'(bz_s[0]), 32'd0);
    chk("sp_grant", 32'(gr_s[0]), 32'd0);
    chk("sp_tv",    32'(tv_s[0]), 32'd0);
    chk("sp_ptr",   32'(u_lock.ptr_q), 32'd3);

    // reset during WAIT abandons the byte; afterwards requester 0 wins first
    dly = 20;
    sb_push(0, 4'b0100, 8'h77);
    send(2, 8'h77, 1'b1);
    n = 0;
    while (!tv_s[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rw_inwait", 32'(tv_s[0]), 32'd1);
    rn_s[0] = 1'b0;
    @(negedge clk);
    chk("rw_tv",    32'(tv_s[0]), 32'd0);
    chk("rw_grant", 32'(gr_s[0]), 32'd0);
    chk("rw_busy",  32'(bz_s[0]), 32'd0);
    dly = 3;
    sb_push(0, 4'b0001, 8'h30);
    sb_push(0, 4'b0100, 8'h32);
    send(2, 8'h32, 1'b1);
    send(0, 8'h30, 1'b1);
    @(negedge clk);
    rn_s[0] = 1'b1;
    wait_drain(200);

    // LOCK=0, all four requesting: order 0,1,2,3,0
    act = 1;
    dly = 2;
    for (int r = 0; r < 4; r++) base[r] = rdy_cnt[r];
    sb_push(1, 4'b0001, 8'h10);
    sb_push(1, 4'b0010, 8'h11);
    sb_push(1, 4'b0100, 8'h12);
    sb_push(1, 4'b1000, 8'h13);
    sb_push(1, 4'b0001, 8'h20);
    send(0, 8'h10, 1'b1);
    send(1, 8'h11, 1'b1);
    send(2, 8'h12, 1'b1);
    send(3, 8'h13, 1'b1);
    send(0, 8'h20, 1'b1);
    wait_drain(300);
    chk("nl_rdy0", 32'(rdy_cnt[0] - base[0]), 32'd2);
    chk("nl_rdy1", 32'(rdy_cnt[1] - base[1]), 32'd1);
    chk("nl_rdy2", 32'(rdy_cnt[2] - base[2]), 32'd1);
    chk("nl_rdy3", 32'(rdy_cnt[3] - base[3]), 32'd1);

    // MAX_BURST=2: req 0 streams 5 bytes, req 1 pending with two single-byte packets
    act = 2;
    dly = 2;
    sb_push(2, 4'b0001, 8'h01);
    sb_push(2, 4'b0001, 8'h02);
    sb_push(2, 4'b0010, 8'h81);
    sb_push(2, 4'b0001, 8'h03);
    sb_push(2, 4'b0001, 8'h04);
    sb_push(2, 4'b0010, 8'h82);
    sb_push(2, 4'b0001, 8'h05);
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0);
    send(1, 8'h81, 1'b1);
    send(1, 8'h82, 1'b1);
    wait_drain(400);
    chk("mb_max_cnt", 32'(max_cnt2), 32'd2);

    chk("sb_empty", 32'(eq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among NUM_REQ byte-stream requesters (console, debug monitor, DMA log, and so on). It sits between the requesters and the UART CSR's TX path. It drives the `txd`/`tx_vld` holding interface and consumes the single-cycle `tx_done` pulse. Optional packet locking keeps a requester granted across back-to-back bytes until it flags the last byte, or until a burst limit forces rotation.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..8.
- MAX_BURST, 64: maximum bytes per grant, legal range 1..255.
- LOCK, 1: 1 holds the grant across bytes until last/limit; 0 re-arbitrates after every byte.

Ports:
- clk  in  1  clock; the only clock.
- reset_n  in  1  reset, synchronous and active-low.
- req_data  in  NUM_REQ*8  byte of requester i at [8i+7:8i].
- req_vld  in  NUM_REQ  requester i has a byte. Once asserted, it must hold, with data stable, until req_rdy[i].
- req_last  in  NUM_REQ  byte presented by requester i ends its packet.
- req_rdy  out  NUM_REQ  byte of requester i accepted this cycle.
- txd  out  8  byte to the UART transmitter.
- tx_vld  out  1  txd valid; held until tx_done.
- tx_done  in  1  single-cycle pulse: byte transmitted.
- grant  out  NUM_REQ  one-hot current owner, or all zero.
- busy  out  1  state is not IDLE.

## Operation
- State machine states: IDLE, LOAD, WAIT.
- IDLE:
  - If req_vld is nonzero, pick the first requester with req_vld set, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Register grant as one-hot of the winner and go to LOAD.
  - Reset burst count cnt to 0.
- LOAD, owner i:
  - req_rdy[i] = req_vld[i], combinational from state, grant and req_vld. All other req_rdy bits are 0.
  - If req_vld[i]=1: txd<=req_data[i], last_q<=req_last[i], tx_vld<=1, go to WAIT.
  - If req_vld[i]=0 (protocol violation): no transfer, ptr<=i, grant<=0, go to IDLE.
- WAIT:
  - Hold txd and tx_vld until tx_done=1.
  - On tx_done=1: tx_vld<=0, cnt<=cnt+1.
  - Release when any of the following holds: LOCK=0, last_q=1, cnt+1==MAX_BURST, or req_vld[i]=0 in that cycle.
  - On release: ptr<=i, grant<=0, go to IDLE. Otherwise stay granted and go to LOAD.
- cnt is 8 bits and is compared against MAX_BURST before increment, so it never wraps.
- tx_done outside WAIT is ignored.
- ptr is log2(NUM_REQ) bits. Its reset value is NUM_REQ-1, so requester 0 has first priority.
- busy = (state != IDLE).

## Timing
- Reset values:
  - State: state=IDLE, ptr=NUM_REQ-1, cnt=0, last_q=0.
  - Outputs: grant=0, req_rdy=0, txd=8'h00, tx_vld=0, busy=0.
- Reset mid-operation: the in-flight byte is abandoned. tx_vld=0 and grant=0 from the first edge with reset_n=0.
- Arbitration latency:
  - req_vld sampled in IDLE at edge t: grant and LOAD from t+1.
  - req_rdy is high during cycle t+1.
  - tx_vld rises at t+2.
- tx_done in cycle w:
  - tx_vld falls at w+1.
  - Locked continuation gives LOAD at w+1 and the next tx_vld at w+2.
  - Release gives IDLE at w+1 and a new grant at w+2.
- Minimum gap between bytes: tx_vld is low for 1 cycle when the owner continues, and 2 cycles on re-arbitration.
- Exactly one req_rdy pulse per byte. No byte is duplicated or dropped while the protocol is obeyed.
- Simultaneous requests are resolved by the rotating pointer only. A requester that loses waits at most NUM_REQ-1 grants.
- A request arriving in LOAD or WAIT from a non-owner is not granted until the next IDLE.

## Test plan
- Single requester: req 2 sends 8'h41 with last=1 and tx_done 10 cycles after tx_vld.
  - req_rdy[2] is high 1 cycle after req_vld.
  - txd=8'h41 and tx_vld are high 2 cycles after req_vld, for 10 cycles.
  - grant returns to 0 and ptr becomes 2.
- All four requesters hold vld after reset with LOCK=0, each sending one byte:
  - Grant order is 0,1,2,3 and then 0 again.
  - Each requester sees exactly one req_rdy per byte.
- LOCK=1: req 1 streams "ABC" with last only on 'C' while req 3 is pending:
  - txd sequence is 41,42,43, all under grant[1].
  - grant[3] is issued only after 'C' completes.
- MAX_BURST=2: req 0 streams 5 bytes with no last while req 1 is pending:
  - Grants alternate 0,0,1,0,0,1,0.
  - cnt never exceeds 2.
- Spurious tx_done in IDLE: no state change. Assert reset_n=0 during WAIT:
  - tx_vld=0, grant=0 and busy=0 the next cycle.
  - After release, requester 0 wins first.
